bin_seg_conv: RTL and testbench

Parametrised successor of the 4-digit integer-to-seven-segment converter. It converts a BIN_W-bit unsigned or two's-complement number to N_DIGITS seven-segment codes using sequential double-dabble, one shift per clock. It adds signed display, leading-zero blanking, range-overflow detection, a busy flag and a fixed-latency start/done handshake. It sits between the calculator ALU result register and the display multiplexer.

---
 rtl/bin_seg_conv.sv | 169 ++++++++++++++++
 tb/tb_bin_seg_conv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_seg_conv.sv
// Binary to seven-segment converter. Uses serial double-dabble, one shift per clock.
// Supports signed display, leading-zero blanking, overflow detection and a fixed-latency done pulse.
module bin_seg_conv #(
   parameter int BIN_W    = 14,
   parameter int N_DIGITS = 4,
   parameter int SIGNED   = 0,
   parameter int BLANK_LZ = 1,
   parameter logic [8*N_DIGITS-1:0] ERR_PATTERN = (8*N_DIGITS)'(32'h763D507C)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BIN_W-1:0]        num,
   input  logic                    convert,
   input  logic                    error,
   output logic                    busy,
   output logic [8*N_DIGITS-1:0]   digits,
   output logic                    overflow,
   output logic                    conv_done
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] MAX_POS = pow10(N_DIGITS) - 64'd1;
   localparam logic [63:0] MAX_NEG = pow10(N_DIGITS - 1) - 64'd1;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

   state_t                state, state_next;
   logic [BIN_W-1:0]      bin_reg;
   logic [BCD_W-1:0]      bcd_reg;
   logic [BCD_W-1:0]      bcd_adj;
   logic [CNT_W-1:0]      cnt;
   logic                  neg_reg, ovf_reg;
   logic                  load_neg, load_ovf;
   logic [BIN_W-1:0]      load_mag;
   logic [63:0]           mag64;
   logic [8*N_DIGITS-1:0] enc_digits;
   logic                  do_load, do_shift, do_encode, do_err;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Error aborts from any state; a conversion always runs BIN_W shifts plus one encode cycle.
   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      do_shift   = 1'b0;
      do_encode  = 1'b0;
      do_err     = 1'b0;
      case (state)
         IDLE: begin
            if (error) begin
               do_err = 1'b1;
            end else if (convert) begin
               do_load    = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (error) begin
               do_err     = 1'b1;
               state_next = IDLE;
            end else begin
               do_shift = 1'b1;
               if (cnt == CNT_W'(BIN_W - 1)) state_next = ENCODE;
            end
         end
         ENCODE: begin
            if (error) do_err = 1'b1;
            else       do_encode = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      load_neg = (SIGNED != 0) && num[BIN_W-1];
      load_mag = load_neg ? (~num + BIN_W'(1)) : num;
      mag64    = 64'(load_mag);
      load_ovf = load_neg ? (mag64 > MAX_NEG) : (mag64 > MAX_POS);
   end

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
         else                           bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4];
      end
   end

   // Walk from the top digit down; a digit is blanked while no nonzero digit has been seen yet.
   always_comb begin
      logic       lead;
      logic [3:0] nib;
      enc_digits = '0;
      lead       = 1'b1;
      nib        = 4'd0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         nib = bcd_reg[4*i +: 4];
         if (nib != 4'd0) lead = 1'b0;
         if ((BLANK_LZ != 0) && lead && (i != 0)) enc_digits[8*i +: 8] = 8'h00;
         else                                     enc_digits[8*i +: 8] = {1'b0, seg7(nib)};
      end
      if (neg_reg) enc_digits[8*(N_DIGITS-1) +: 8] = 8'h40;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits    <= '0;
         overflow  <= 1'b0;
         conv_done <= 1'b0;
         bin_reg   <= '0;
         bcd_reg   <= '0;
         cnt       <= '0;
         neg_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         if (do_err) begin
            digits    <= ERR_PATTERN;
            overflow  <= 1'b0;
            conv_done <= 1'b1;
         end else if (do_load) begin
            bin_reg <= load_mag;
            bcd_reg <= '0;
            cnt     <= '0;
            neg_reg <= load_neg;
            ovf_reg <= load_ovf;
         end else if (do_shift) begin
            {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
            cnt                <= cnt + CNT_W'(1);
         end else if (do_encode) begin
            digits    <= ovf_reg ? ERR_PATTERN : enc_digits;
            overflow  <= ovf_reg;
            conv_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bin_seg_conv.sv
// Bench for bin_seg_conv: three variants (default, no blanking, signed) against a decimal-arithmetic model.
module tb_bin_seg_conv;

   localparam logic [31:0] ERR = 32'h763D507C;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [2:0][13:0]  num_s = '0;
   logic [2:0]        convert_s = '0;
   logic [2:0]        error_s = '0;
   logic [2:0]        busy_s, done_s, ovf_s;
   logic [2:0][31:0]  digits_s;
   logic              busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
   logic [31:0]       dig0, dig1, dig2;

   int   errors = 0;
   int   checks = 0;
   bit   check_en = 1'b0;

   int          m_rem [3] = '{0, 0, 0};
   logic [13:0] m_val [3];
   logic [31:0] m_dig [3];
   logic        m_ovf [3];
   logic        m_done[3];

   always #5 clk = ~clk;

   bin_seg_conv u_dut (.clk(clk), .rst(rst), .num(num_s[0]), .convert(convert_s[0]), .error(error_s[0]),
                       .busy(busy0), .digits(dig0), .overflow(ovf0), .conv_done(done0));
   bin_seg_conv #(.BLANK_LZ(0)) u_nolz (.clk(clk), .rst(rst), .num(num_s[1]), .convert(convert_s[1]),
                       .error(error_s[1]), .busy(busy1), .digits(dig1), .overflow(ovf1), .conv_done(done1));
   bin_seg_conv #(.SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .num(num_s[2]), .convert(convert_s[2]),
                       .error(error_s[2]), .busy(busy2), .digits(dig2), .overflow(ovf2), .conv_done(done2));

   assign busy_s   = {busy2, busy1, busy0};
   assign done_s   = {done2, done1, done0};
   assign ovf_s    = {ovf2, ovf1, ovf0};
   assign digits_s = {dig2, dig1, dig0};

   function automatic logic [7:0] segOf(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;  4: return 8'h66;
         5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;  8: return 8'h7F;  default: return 8'h6F;
      endcase
   endfunction

   // Decimal reference: overflow flag in bit 32, display code below.
   function automatic logic [32:0] modelConv(input logic [13:0] v, input bit sgn, input bit blank);
      int          val, mag, p;
      bit          neg;
      logic [31:0] d;
      val = int'(v);
      if (sgn && v[13]) val = val - 16384;
      neg = (val < 0);
      mag = neg ? -val : val;
      if (mag > (neg ? 999 : 9999)) return {1'b1, ERR};
      d = '0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         if (blank && i > 0 && mag < p) d[8*i +: 8] = 8'h00;
         else                           d[8*i +: 8] = segOf((mag / p) % 10);
         p = p * 10;
      end
      if (neg) d[31:24] = 8'h40;
      return {1'b0, d};
   endfunction

   // Behavioural timing: a conversion stays in flight for BIN_W+1 cycles, then reports.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_rem[k] <= 0;  m_dig[k] <= '0;  m_ovf[k] <= 1'b0;  m_done[k] <= 1'b0;
         end else begin
            m_done[k] <= 1'b0;
            if (m_rem[k] == 0) begin
               if (error_s[k]) begin
                  m_dig[k] <= ERR;  m_ovf[k] <= 1'b0;  m_done[k] <= 1'b1;
               end else if (convert_s[k]) begin
                  m_val[k] <= num_s[k];  m_rem[k] <= 15;
               end
            end else if (error_s[k]) begin
               m_dig[k] <= ERR;  m_ovf[k] <= 1'b0;  m_done[k] <= 1'b1;  m_rem[k] <= 0;
            end else begin
               m_rem[k] <= m_rem[k] - 1;
               if (m_rem[k] == 1) begin
                  {m_ovf[k], m_dig[k]} <= modelConv(m_val[k], k == 2, k != 1);
                  m_done[k] <= 1'b1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("d%0d busy", k), 64'(busy_s[k]), 64'(m_rem[k] != 0));
            checkOutput($sformatf("d%0d conv_done", k), 64'(done_s[k]), 64'(m_done[k]));
            checkOutput($sformatf("d%0d digits", k), 64'(digits_s[k]), 64'(m_dig[k]));
            checkOutput($sformatf("d%0d overflow", k), 64'(ovf_s[k]), 64'(m_ovf[k]));
         end
      end
   end

   // Pulse convert on variant k and wait (bounded) for conv_done; reports latency and busy cycles.
   task automatic applyStimulus(input int k, input logic [13:0] value, output int lat, output int busyCnt);
      @(negedge clk);
      num_s[k]     = value;
      convert_s[k] = 1'b1;
      @(negedge clk);
      convert_s[k] = 1'b0;
      lat     = 1;
      busyCnt = 0;
      while (!done_s[k] && lat < 40) begin
         if (busy_s[k]) busyCnt++;
         @(negedge clk);
         lat++;
      end
      if (!done_s[k]) checkOutput("conv_done timeout", 64'(done_s[k]), 64'd1);
   endtask

   initial begin
      int lat, bc;
      repeat (3) @(negedge clk);
      checkOutput("reset digits", 64'(dig0), 64'h0);
      checkOutput("reset busy", 64'(busy0), 64'h0);
      checkOutput("reset conv_done", 64'(done0), 64'h0);
      checkOutput("reset overflow", 64'(ovf0), 64'h0);
      rst      = 1'b0;
      check_en = 1'b1;

      applyStimulus(0, 14'd1234, lat, bc);
      checkOutput("1234 latency", 64'(lat), 64'd16);
      checkOutput("1234 busy cycles", 64'(bc), 64'd15);
      checkOutput("1234 digits", 64'(dig0), 64'h065B4F66);
      checkOutput("1234 overflow", 64'(ovf0), 64'h0);

      applyStimulus(0, 14'd7, lat, bc);
      checkOutput("7 blanked", 64'(dig0), 64'h00000007);
      applyStimulus(0, 14'd0, lat, bc);
      checkOutput("0 blanked", 64'(dig0), 64'h0000003F);
      applyStimulus(1, 14'd7, lat, bc);
      checkOutput("7 unblanked", 64'(dig1), 64'h3F3F3F07);

      applyStimulus(0, 14'd10000, lat, bc);
      checkOutput("10000 latency", 64'(lat), 64'd16);
      checkOutput("10000 overflow", 64'(ovf0), 64'h1);
      checkOutput("10000 digits", 64'(dig0), 64'(ERR));
      applyStimulus(0, 14'd9999, lat, bc);
      checkOutput("9999 digits", 64'(dig0), 64'h6F6F6F6F);
      checkOutput("9999 overflow", 64'(ovf0), 64'h0);

      applyStimulus(2, 14'h3FD6, lat, bc);
      checkOutput("-42 digits", 64'(dig2), 64'h4000665B);
      applyStimulus(2, 14'h3C19, lat, bc);
      checkOutput("-999 digits", 64'(dig2), 64'h406F6F6F);
      checkOutput("-999 overflow", 64'(ovf2), 64'h0);
      applyStimulus(2, 14'h3C18, lat, bc);
      checkOutput("-1000 overflow", 64'(ovf2), 64'h1);
      checkOutput("-1000 digits", 64'(dig2), 64'(ERR));
      applyStimulus(2, 14'h2000, lat, bc);
      checkOutput("-8192 overflow", 64'(ovf2), 64'h1);

      // Abort by error mid-conversion, with a stray convert while busy.
      @(negedge clk);  num_s[0] = 14'd1234;  convert_s[0] = 1'b1;
      @(negedge clk);  convert_s[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);  convert_s[0] = 1'b1;
      @(negedge clk);  convert_s[0] = 1'b0;
      @(negedge clk);  error_s[0] = 1'b1;
      @(negedge clk);  error_s[0] = 1'b0;
      checkOutput("abort conv_done", 64'(done0), 64'h1);
      checkOutput("abort busy", 64'(busy0), 64'h0);
      checkOutput("abort digits", 64'(dig0), 64'(ERR));
      @(negedge clk);
      checkOutput("abort done one cycle", 64'(done0), 64'h0);

      @(negedge clk);  num_s[0] = 14'd5;  error_s[0] = 1'b1;  convert_s[0] = 1'b1;
      @(negedge clk);  error_s[0] = 1'b0;  convert_s[0] = 1'b0;
      checkOutput("err+conv conv_done", 64'(done0), 64'h1);
      checkOutput("err+conv busy", 64'(busy0), 64'h0);
      @(negedge clk);
      checkOutput("err+conv no start", 64'(busy0), 64'h0);

      // Reset in cycle 8 of a conversion.
      @(negedge clk);  num_s[0] = 14'd4321;  convert_s[0] = 1'b1;
      @(negedge clk);  convert_s[0] = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk);  rst = 1'b1;
      @(negedge clk);  rst = 1'b0;
      checkOutput("rst conv_done", 64'(done0), 64'h0);
      checkOutput("rst digits", 64'(dig0), 64'h0);
      checkOutput("rst busy", 64'(busy0), 64'h0);
      applyStimulus(0, 14'd4321, lat, bc);
      checkOutput("after rst latency", 64'(lat), 64'd16);
      checkOutput("4321 digits", 64'(dig0), 64'h664F5B06);

      repeat (3) @(negedge clk);
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation timeout");
   end

endmodule
